// File: rtl/enc_tx_ctrl.sv
// 8b/10b transmit link controller: post-reset K28.5 alignment burst, SOF/EOF framing,
// idle/underrun fill and abort, driving a table-based combinational 8b/10b encoder.

module encode (
    input  logic [8:0] datain,
    input  logic       dispin,
    output logic [9:0] dataout,
    output logic       dispout
);
    logic [4:0] x;
    logic [2:0] y;
    logic       k;
    logic       k28;
    logic [5:0] six_n;
    logic [3:0] four_n;
    logic       unbal6;
    logic       unbal4;
    logic       six_flip;
    logic       four_flip;
    logic       rd6;
    logic       use_a7;
    logic [5:0] six;
    logic [3:0] four;

    assign x   = datain[4:0];
    assign y   = datain[7:5];
    assign k   = datain[8];
    assign k28 = k && (x == 5'd28);

    // 5b/6b sub-block; table holds the RD- form as abcdei, MSB = a
    always_comb begin
        six_n = 6'b000000;
        if (k28) begin
            six_n = 6'b001111;
        end else begin
            case (x)
                5'd0:  six_n = 6'b100111;
                5'd1:  six_n = 6'b011101;
                5'd2:  six_n = 6'b101101;
                5'd3:  six_n = 6'b110001;
                5'd4:  six_n = 6'b110101;
                5'd5:  six_n = 6'b101001;
                5'd6:  six_n = 6'b011001;
                5'd7:  six_n = 6'b111000;
                5'd8:  six_n = 6'b111001;
                5'd9:  six_n = 6'b100101;
                5'd10: six_n = 6'b010101;
                5'd11: six_n = 6'b110100;
                5'd12: six_n = 6'b001101;
                5'd13: six_n = 6'b101100;
                5'd14: six_n = 6'b011100;
                5'd15: six_n = 6'b010111;
                5'd16: six_n = 6'b011011;
                5'd17: six_n = 6'b100011;
                5'd18: six_n = 6'b010011;
                5'd19: six_n = 6'b110010;
                5'd20: six_n = 6'b001011;
                5'd21: six_n = 6'b101010;
                5'd22: six_n = 6'b011010;
                5'd23: six_n = 6'b111010;
                5'd24: six_n = 6'b110011;
                5'd25: six_n = 6'b100110;
                5'd26: six_n = 6'b010110;
                5'd27: six_n = 6'b110110;
                5'd28: six_n = 6'b001110;
                5'd29: six_n = 6'b101110;
                5'd30: six_n = 6'b011110;
                default: six_n = 6'b101011;
            endcase
        end
    end

    assign unbal6   = ($countones(six_n) != 3);
    assign six_flip = unbal6 || ((x == 5'd7) && !k);
    assign six      = (six_flip && dispin) ? ~six_n : six_n;
    assign rd6      = dispin ^ unbal6;

    // Alternate x.7 avoids a run of five equal bits across the 6b/4b boundary
    assign use_a7 = (y == 3'd7) && (k ||
                    (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                    ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));

    always_comb begin
        four_n = 4'b0000;
        if (k28) begin
            case (y)
                3'd0: four_n = 4'b1011;
                3'd1: four_n = 4'b0110;
                3'd2: four_n = 4'b1010;
                3'd3: four_n = 4'b1100;
                3'd4: four_n = 4'b1101;
                3'd5: four_n = 4'b0101;
                3'd6: four_n = 4'b1001;
                default: four_n = 4'b0111;
            endcase
        end else begin
            case (y)
                3'd0: four_n = 4'b1011;
                3'd1: four_n = 4'b1001;
                3'd2: four_n = 4'b0101;
                3'd3: four_n = 4'b1100;
                3'd4: four_n = 4'b1101;
                3'd5: four_n = 4'b1010;
                3'd6: four_n = 4'b0110;
                default: four_n = use_a7 ? 4'b0111 : 4'b1110;
            endcase
        end
    end

    assign unbal4    = ($countones(four_n) != 2);
    assign four_flip = unbal4 || (y == 3'd3) || k28;
    assign four      = (four_flip && rd6) ? ~four_n : four_n;
    assign dispout   = rd6 ^ unbal4;

    assign dataout = {four[0], four[1], four[2], four[3],
                      six[0], six[1], six[2], six[3], six[4], six[5]};
endmodule

module enc_tx_ctrl #(
    parameter int ALIGN_LEN = 16,
    parameter int MIN_IDLE  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       link_en,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic [9:0] tx_sym,
    output logic       tx_rd,
    output logic       frame_active,
    output logic       sts_underrun,
    output logic       sts_abort
);
    typedef enum logic [2:0] {
        ST_ALIGN,
        ST_IDLE,
        ST_SOF,
        ST_DATA,
        ST_EOF,
        ST_ABORT
    } state_t;

    localparam logic [8:0] K28_5      = 9'h1BC;
    localparam logic [8:0] K27_7      = 9'h1FB;
    localparam logic [8:0] K29_7      = 9'h1FD;
    localparam logic [8:0] K30_7      = 9'h1FE;
    localparam logic [7:0] ALIGN_LAST = 8'(ALIGN_LEN - 1);
    localparam logic [8:0] MIN_IDLE_W = 9'(MIN_IDLE);

    state_t     state_q, state_d;
    logic [7:0] align_cnt_q, align_cnt_d;
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic       rd_q, rd_d;
    logic [9:0] tx_sym_q, tx_sym_d;
    logic       frame_active_q, frame_active_d;
    logic       underrun_q, underrun_d;
    logic       abort_q, abort_d;
    logic [8:0] code;
    logic       idle_met;

    encode u_encode (
        .datain  (code),
        .dispin  (rd_q),
        .dataout (tx_sym_d),
        .dispout (rd_d)
    );

    // Counts the idle symbol being emitted now, so it may be the last one before SOF
    assign idle_met = ({1'b0, idle_cnt_q} + 9'd1) >= MIN_IDLE_W;

    always_comb begin
        state_d        = state_q;
        align_cnt_d    = align_cnt_q;
        idle_cnt_d     = idle_cnt_q;
        code           = K28_5;
        s_ready        = 1'b0;
        frame_active_d = 1'b0;
        underrun_d     = 1'b0;
        abort_d        = 1'b0;
        case (state_q)
            ST_ALIGN: begin
                if (align_cnt_q == ALIGN_LAST) begin
                    state_d    = ST_IDLE;
                    idle_cnt_d = 8'hFF;
                end else begin
                    align_cnt_d = align_cnt_q + 8'd1;
                end
            end
            ST_IDLE: begin
                if (idle_cnt_q != 8'hFF) begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
                if (link_en && s_valid && idle_met) begin
                    state_d = ST_SOF;
                end
            end
            ST_SOF: begin
                code           = K27_7;
                frame_active_d = 1'b1;
                state_d        = link_en ? ST_DATA : ST_ABORT;
            end
            ST_DATA: begin
                frame_active_d = 1'b1;
                s_ready        = link_en;
                if (!link_en) begin
                    state_d = ST_ABORT;
                end else if (s_valid) begin
                    code = {1'b0, s_data};
                    if (s_last) begin
                        state_d = ST_EOF;
                    end
                end else begin
                    underrun_d = 1'b1;
                end
            end
            ST_EOF: begin
                code           = K29_7;
                frame_active_d = 1'b1;
                state_d        = ST_IDLE;
                idle_cnt_d     = 8'd0;
            end
            ST_ABORT: begin
                code       = K30_7;
                abort_d    = 1'b1;
                state_d    = ST_IDLE;
                idle_cnt_d = 8'd0;
            end
            default: begin
                state_d = ST_ALIGN;
            end
        endcase
        if (rst) begin
            s_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_ALIGN;
            align_cnt_q    <= 8'd0;
            idle_cnt_q     <= 8'd0;
            rd_q           <= 1'b0;
            tx_sym_q       <= 10'h000;
            frame_active_q <= 1'b0;
            underrun_q     <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            align_cnt_q    <= align_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            rd_q           <= rd_d;
            tx_sym_q       <= tx_sym_d;
            frame_active_q <= frame_active_d;
            underrun_q     <= underrun_d;
            abort_q        <= abort_d;
        end
    end

    assign tx_sym       = tx_sym_q;
    assign tx_rd        = rd_q;
    assign frame_active = frame_active_q;
    assign sts_underrun = underrun_q;
    assign sts_abort    = abort_q;
endmodule

// File: tb/tb_enc_tx_ctrl.sv
// Directed and random bench for enc_tx_ctrl; expected symbols come from a two-column
// 8b/10b reference table and are queued per step, then popped after the clock edge.

module tb_enc_tx_ctrl;
    localparam int ALIGN_LEN = 4;
    localparam int MIN_IDLE  = 2;

    localparam logic [8:0] K285 = 9'h1BC;
    localparam logic [8:0] K277 = 9'h1FB;
    localparam logic [8:0] K297 = 9'h1FD;
    localparam logic [8:0] K307 = 9'h1FE;

    logic       clk;
    logic       rst;
    logic       link_en;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic [9:0] tx_sym;
    logic       tx_rd;
    logic       frame_active;
    logic       sts_underrun;
    logic       sts_abort;

    typedef struct {
        string      tag;
        logic [9:0] sym;
        logic       rd;
        logic       fa;
        logic       und;
        logic       abt;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic model_rd = 1'b0;

    enc_tx_ctrl #(
        .ALIGN_LEN (ALIGN_LEN),
        .MIN_IDLE  (MIN_IDLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .link_en      (link_en),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .tx_sym       (tx_sym),
        .tx_rd        (tx_rd),
        .frame_active (frame_active),
        .sts_underrun (sts_underrun),
        .sts_abort    (sts_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {RD- form, RD+ form} of the 6b code, abcdei with a as MSB
    function automatic logic [11:0] six_pair(input logic [4:0] x);
        case (x)
            5'd0:  return {6'b100111, 6'b011000};
            5'd1:  return {6'b011101, 6'b100010};
            5'd2:  return {6'b101101, 6'b010010};
            5'd3:  return {6'b110001, 6'b110001};
            5'd4:  return {6'b110101, 6'b001010};
            5'd5:  return {6'b101001, 6'b101001};
            5'd6:  return {6'b011001, 6'b011001};
            5'd7:  return {6'b111000, 6'b000111};
            5'd8:  return {6'b111001, 6'b000110};
            5'd9:  return {6'b100101, 6'b100101};
            5'd10: return {6'b010101, 6'b010101};
            5'd11: return {6'b110100, 6'b110100};
            5'd12: return {6'b001101, 6'b001101};
            5'd13: return {6'b101100, 6'b101100};
            5'd14: return {6'b011100, 6'b011100};
            5'd15: return {6'b010111, 6'b101000};
            5'd16: return {6'b011011, 6'b100100};
            5'd17: return {6'b100011, 6'b100011};
            5'd18: return {6'b010011, 6'b010011};
            5'd19: return {6'b110010, 6'b110010};
            5'd20: return {6'b001011, 6'b001011};
            5'd21: return {6'b101010, 6'b101010};
            5'd22: return {6'b011010, 6'b011010};
            5'd23: return {6'b111010, 6'b000101};
            5'd24: return {6'b110011, 6'b001100};
            5'd25: return {6'b100110, 6'b100110};
            5'd26: return {6'b010110, 6'b010110};
            5'd27: return {6'b110110, 6'b001001};
            5'd28: return {6'b001110, 6'b001110};
            5'd29: return {6'b101110, 6'b010001};
            5'd30: return {6'b011110, 6'b100001};
            default: return {6'b101011, 6'b010100};
        endcase
    endfunction

    function automatic logic [7:0] four_pair(input logic k28, input logic a7, input logic [2:0] y);
        if (k28) begin
            case (y)
                3'd0: return {4'b1011, 4'b0100};
                3'd1: return {4'b0110, 4'b1001};
                3'd2: return {4'b1010, 4'b0101};
                3'd3: return {4'b1100, 4'b0011};
                3'd4: return {4'b1101, 4'b0010};
                3'd5: return {4'b0101, 4'b1010};
                3'd6: return {4'b1001, 4'b0110};
                default: return {4'b0111, 4'b1000};
            endcase
        end
        case (y)
            3'd0: return {4'b1011, 4'b0100};
            3'd1: return {4'b1001, 4'b1001};
            3'd2: return {4'b0101, 4'b0101};
            3'd3: return {4'b1100, 4'b0011};
            3'd4: return {4'b1101, 4'b0010};
            3'd5: return {4'b1010, 4'b1010};
            3'd6: return {4'b0110, 4'b0110};
            default: return a7 ? {4'b0111, 4'b1000} : {4'b1110, 4'b0001};
        endcase
    endfunction

    task automatic enc_ref(input logic [8:0] code, input logic rd_in,
                           output logic [9:0] sym, output logic rd_out);
        logic [11:0] sp;
        logic [7:0]  fp;
        logic [5:0]  six;
        logic [3:0]  four;
        logic        rd6;
        logic        k28;
        logic        a7;
        logic [4:0]  x;
        x   = code[4:0];
        k28 = code[8] && (x == 5'd28);
        sp  = k28 ? {6'b001111, 6'b110000} : six_pair(x);
        six = rd_in ? sp[5:0] : sp[11:6];
        rd6 = ($countones(six) == 3) ? rd_in : !rd_in;
        a7  = code[8] || (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
              (rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14));
        fp  = four_pair(k28, a7, code[7:5]);
        four = rd6 ? fp[3:0] : fp[7:4];
        rd_out = ($countones(four) == 2) ? rd6 : !rd6;
        sym = {four[0], four[1], four[2], four[3], six[0], six[1], six[2], six[3], six[4], six[5]};
    endtask

    task automatic check_val(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb_q.pop_front();
        check_val({e.tag, ".tx_sym"}, tx_sym, e.sym);
        check_val({e.tag, ".tx_rd"}, {9'd0, tx_rd}, {9'd0, e.rd});
        check_val({e.tag, ".frame_active"}, {9'd0, frame_active}, {9'd0, e.fa});
        check_val({e.tag, ".sts_underrun"}, {9'd0, sts_underrun}, {9'd0, e.und});
        check_val({e.tag, ".sts_abort"}, {9'd0, sts_abort}, {9'd0, e.abt});
    endtask

    // One symbol slot: drive inputs, queue the expected symbol, check s_ready, clock, compare
    task automatic apply_stimulus(input string tag, input logic le, input logic sv,
                                  input logic [7:0] sd, input logic sl, input logic exp_ready,
                                  input logic [8:0] code, input logic exp_fa,
                                  input logic exp_und, input logic exp_abt);
        exp_t e;
        logic nrd;
        link_en = le;
        s_valid = sv;
        s_data  = sd;
        s_last  = sl;
        e.tag = tag;
        enc_ref(code, model_rd, e.sym, nrd);
        model_rd = nrd;
        e.rd  = nrd;
        e.fa  = exp_fa;
        e.und = exp_und;
        e.abt = exp_abt;
        sb_q.push_back(e);
        #1;
        check_val({tag, ".s_ready"}, {9'd0, s_ready}, {9'd0, exp_ready});
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic idle_step(input string tag, input logic le, input logic sv, input logic [7:0] sd);
        apply_stimulus(tag, le, sv, sd, 1'b0, 1'b0, K285, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic align_burst();
        for (int i = 0; i < ALIGN_LEN; i++) begin
            apply_stimulus("align", 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, K285, 1'b0, 1'b0, 1'b0);
            if (i == 0) check_val("align_first_literal", tx_sym, 10'h17C);
            if (i == 1) check_val("align_second_literal", tx_sym, 10'h283);
        end
    endtask

    initial begin
        logic prev_rd;
        logic ok;
        logic hit;
        int   ones;
        rst     = 1'b1;
        link_en = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h00;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset.tx_sym", tx_sym, 10'h000);
        check_val("reset.tx_rd", {9'd0, tx_rd}, 10'd0);
        check_val("reset.frame_active", {9'd0, frame_active}, 10'd0);
        check_val("reset.flags", {8'd0, sts_underrun, sts_abort}, 10'd0);
        check_val("reset.s_ready", {9'd0, s_ready}, 10'd0);
        rst = 1'b0;
        model_rd = 1'b0;
        align_burst();
        idle_step("post_align_idle", 1'b1, 1'b0, 8'h00);
        idle_step("post_align_idle", 1'b1, 1'b0, 8'h00);

        // Single-byte frame
        idle_step("f1_idle", 1'b1, 1'b1, 8'h00);
        apply_stimulus("f1_sof", 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, K277, 1'b1, 1'b0, 1'b0);
        apply_stimulus("f1_d0", 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 9'h000, 1'b1, 1'b0, 1'b0);
        apply_stimulus("f1_eof", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, K297, 1'b1, 1'b0, 1'b0);

        // Back-to-back 3-byte frames, s_valid held high: exactly two idles between them
        idle_step("b2b_gap1", 1'b1, 1'b1, 8'hF1);
        idle_step("b2b_gap2", 1'b1, 1'b1, 8'hF1);
        apply_stimulus("fa_sof", 1'b1, 1'b1, 8'hF1, 1'b0, 1'b0, K277, 1'b1, 1'b0, 1'b0);
        apply_stimulus("fa_d0", 1'b1, 1'b1, 8'hF1, 1'b0, 1'b1, 9'h0F1, 1'b1, 1'b0, 1'b0);
        apply_stimulus("fa_d1", 1'b1, 1'b1, 8'h4A, 1'b0, 1'b1, 9'h04A, 1'b1, 1'b0, 1'b0);
        apply_stimulus("fa_d2", 1'b1, 1'b1, 8'hEB, 1'b1, 1'b1, 9'h0EB, 1'b1, 1'b0, 1'b0);
        apply_stimulus("fa_eof", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, K297, 1'b1, 1'b0, 1'b0);
        idle_step("b2b_gap3", 1'b1, 1'b1, 8'hFF);
        idle_step("b2b_gap4", 1'b1, 1'b1, 8'hFF);
        apply_stimulus("fb_sof", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, K277, 1'b1, 1'b0, 1'b0);
        apply_stimulus("fb_d0", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 9'h0FF, 1'b1, 1'b0, 1'b0);
        apply_stimulus("fb_d1", 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 9'h007, 1'b1, 1'b0, 1'b0);
        apply_stimulus("fb_d2", 1'b1, 1'b1, 8'h91, 1'b1, 1'b1, 9'h091, 1'b1, 1'b0, 1'b0);
        apply_stimulus("fb_eof", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, K297, 1'b1, 1'b0, 1'b0);

        // Underrun: three fills mid-frame, then the next byte resumes the frame
        idle_step("u_idle", 1'b1, 1'b0, 8'h00);
        idle_step("u_idle", 1'b1, 1'b0, 8'h00);
        idle_step("u_idle", 1'b1, 1'b1, 8'h3C);
        apply_stimulus("u_sof", 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, K277, 1'b1, 1'b0, 1'b0);
        apply_stimulus("u_d0", 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 9'h03C, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            apply_stimulus("u_fill", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, K285, 1'b1, 1'b1, 1'b0);
        apply_stimulus("u_d1", 1'b1, 1'b1, 8'hB5, 1'b1, 1'b1, 9'h0B5, 1'b1, 1'b0, 1'b0);
        apply_stimulus("u_eof", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, K297, 1'b1, 1'b0, 1'b0);

        // link_en dropped in DATA: one unflagged fill, then K30.7
        idle_step("x_idle", 1'b1, 1'b0, 8'h00);
        idle_step("x_idle", 1'b1, 1'b0, 8'h00);
        idle_step("x_idle", 1'b1, 1'b1, 8'h12);
        apply_stimulus("x_sof", 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, K277, 1'b1, 1'b0, 1'b0);
        apply_stimulus("x_d0", 1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 9'h012, 1'b1, 1'b0, 1'b0);
        apply_stimulus("x_fill", 1'b0, 1'b1, 8'h34, 1'b0, 1'b0, K285, 1'b1, 1'b0, 1'b0);
        apply_stimulus("x_abort", 1'b0, 1'b1, 8'h34, 1'b0, 1'b0, K307, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            idle_step("x_no_sof", 1'b0, 1'b1, 8'h34);
        idle_step("x_reen", 1'b1, 1'b1, 8'h34);
        apply_stimulus("y_sof", 1'b1, 1'b1, 8'h34, 1'b1, 1'b0, K277, 1'b1, 1'b0, 1'b0);
        apply_stimulus("y_d0", 1'b1, 1'b1, 8'h34, 1'b1, 1'b1, 9'h034, 1'b1, 1'b0, 1'b0);
        apply_stimulus("y_eof", 1'b1, 1'b1, 8'h56, 1'b0, 1'b0, K297, 1'b1, 1'b0, 1'b0);

        // link_en low while in SOF: K27.7 still goes out, then abort
        idle_step("z_idle", 1'b1, 1'b1, 8'h56);
        idle_step("z_idle", 1'b1, 1'b1, 8'h56);
        apply_stimulus("z_sof", 1'b0, 1'b1, 8'h56, 1'b0, 1'b0, K277, 1'b1, 1'b0, 1'b0);
        apply_stimulus("z_abort", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, K307, 1'b0, 1'b0, 1'b1);
        idle_step("z_idle_after", 1'b0, 1'b0, 8'h00);

        // Random traffic: disparity must be legal and consistent with tx_rd
        prev_rd = tx_rd;
        hit = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            link_en = ($urandom_range(0, 9) != 0);
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom_range(0, 255));
            s_last  = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
            ones = $countones(tx_sym);
            ok = ((ones == 5) && (tx_rd == prev_rd)) ||
                 ((ones == 6) && !prev_rd && tx_rd) ||
                 ((ones == 4) && prev_rd && !tx_rd);
            check_val("rand_disparity", {9'd0, ok}, 10'd1);
            prev_rd = tx_rd;
            if (i >= 100 && frame_active) hit = 1'b1;
        end
        check_val("rand_reached_frame", {9'd0, hit}, 10'd1);

        // Reset in the middle of a frame
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("midreset.tx_sym", tx_sym, 10'h000);
        check_val("midreset.tx_rd", {9'd0, tx_rd}, 10'd0);
        check_val("midreset.frame_active", {9'd0, frame_active}, 10'd0);
        check_val("midreset.s_ready", {9'd0, s_ready}, 10'd0);
        rst = 1'b0;
        sb_q.delete();
        model_rd = 1'b0;
        align_burst();
        idle_step("mr_idle", 1'b1, 1'b1, 8'hA5);
        apply_stimulus("mr_sof", 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, K277, 1'b1, 1'b0, 1'b0);
        apply_stimulus("mr_d0", 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 9'h0A5, 1'b1, 1'b0, 1'b0);
        apply_stimulus("mr_eof", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, K297, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/enc_tx_ctrl.md
# enc_tx_ctrl

Transmit-side 8b/10b link controller: it sequences the combinational `encode` block and registers its 10-bit output toward the serializer. It owns the running-disparity register and sends a K28.5 alignment burst after reset. It frames accepted payload bytes with K27.7 (start of frame, SOF) and K29.7 (end of frame, EOF), fills idle and underrun slots with K28.5, and aborts frames with K30.7. It sits between the byte-stream source (valid/ready) and the serializer, emitting exactly one symbol per clock.

## Interface
- `ALIGN_LEN`, 16: number of K28.5 symbols emitted after reset before framing is allowed; legal range 1..255.
- `MIN_IDLE`, 2: minimum number of K28.5 idle symbols between an EOF/abort and the next SOF; legal range 1..255.
- `clk`  in  1  symbol clock. Only clock in the block.
- `rst`  in  1  synchronous, active-high reset.
- `link_en`  in  1  permits frame start; low mid-frame forces an abort.
- `s_valid`  in  1  payload byte valid.
- `s_data`  in  8  payload byte, encoded as a D code.
- `s_last`  in  1  marks the last byte of a frame; qualified by `s_valid & s_ready`.
- `s_ready`  out  1  byte accepted this cycle; combinational from state and `link_en`.
- `tx_sym`  out  10  registered encoded symbol, `{j,h,g,f,i,e,d,c,b,a}`.
- `tx_rd`  out  1  running disparity after `tx_sym` (0 = negative, 1 = positive).
- `frame_active`  out  1  high while in the SOF, DATA or EOF state.
- `sts_underrun`  out  1  one-cycle pulse per mid-frame fill symbol.
- `sts_abort`  out  1  one-cycle pulse when K30.7 is emitted.

## Operation
- One `encode` instance is driven by a 9-bit code `{k, byte}` selected from the state, with `dispin` = the `rd` register.
- Every clock: `tx_sym <= dataout` and `rd <= dispout`; `tx_rd` mirrors `rd`.
- Codes used:
  - K28.5 = `{1,8'hBC}`
  - K27.7 = `{1,8'hFB}`
  - K29.7 = `{1,8'hFD}`
  - K30.7 = `{1,8'hFE}`
  - data = `{0,s_data}`
- States and transitions:
  - **ALIGN**: emit K28.5; align counter increments. After the `ALIGN_LEN`-th symbol → IDLE, with the idle counter preset to saturated. `link_en` is ignored.
  - **IDLE**: emit K28.5; the idle counter increments, saturating at 255. The idle symbol that makes idle count ≥ `MIN_IDLE` may be the last before SOF. If `link_en & s_valid` and the requirement is met → SOF.
  - **SOF**: emit K27.7 → DATA. If `link_en` is low → ABORT instead, and K27.7 is still emitted this cycle.
  - **DATA**:
    - `s_ready = link_en`.
    - If `s_valid & link_en`: encode `s_data`. With `s_last` → EOF; otherwise stay.
    - If `!s_valid & link_en`: emit K28.5 fill, pulse `sts_underrun`, stay.
    - If `!link_en`: → ABORT. Emit a K28.5 fill this cycle, with no `sts_underrun` pulse and nothing consumed.
  - **EOF**: emit K29.7 → IDLE, idle counter cleared.
  - **ABORT**: emit K30.7, pulse `sts_abort` → IDLE, idle counter cleared.
- `s_ready` is 0 in every state except DATA.
- Bytes are never consumed outside DATA, and no byte is dropped or duplicated.
- A frame of N bytes occupies N+2 symbols plus any fills.
- Reset: state = ALIGN, all counters = 0, `rd` = 0.
- Reset mid-frame: the frame is dropped with no EOF or abort symbol; ALIGN restarts and `rd` returns to 0.

## Timing
- Reset values:
  - `tx_sym` = 10'h000
  - `tx_rd` = 0
  - `frame_active` = 0
  - `sts_underrun` = 0
  - `sts_abort` = 0
  - `s_ready` = 0 while `rst` is high
- First edge after `rst` falls: `tx_sym` = 10'h17C (K28.5, RD−), `tx_rd` = 1.
- Latency: a byte accepted in cycle n appears on `tx_sym` after the edge ending cycle n, i.e. 1 cycle.
- `sts_underrun` and `sts_abort` are registered and aligned with the `tx_sym` they describe.
- `frame_active` is registered with the same alignment: high for the SOF through EOF symbols, low on the K30.7 symbol.
- `rd` always updates from `dispout`. Controller-inserted symbols follow the same disparity rules as data.

## Test plan
- `ALIGN_LEN`=4, release reset: `tx_sym` = 17C, 283, 17C, 283, then idles continue alternating 17C/283. `s_ready` stays 0 throughout ALIGN even with `s_valid`=1.
- After align, 1-byte frame `s_data`=8'h00 with `s_last`: `tx_sym` = K27.7, D0.0, K29.7, encoded with tracked RD and checked against a golden 8b/10b model. `s_ready` is high exactly 1 cycle; the byte appears 1 cycle after acceptance.
- Back-to-back 3-byte frames with `s_valid` held high, `MIN_IDLE`=2: exactly 2 K28.5 symbols between the first K29.7 and the second K27.7. All 6 bytes arrive in order.
- Drop `s_valid` for 3 cycles mid-frame: 3 K28.5 fills, 3 `sts_underrun` pulses, the frame resumes with the next byte, and the byte count is unchanged.
- Deassert `link_en` in DATA: one K28.5 fill, then K30.7 with `sts_abort`=1 and `frame_active`=0, then idles. No SOF occurs while `link_en`=0. Re-enable: SOF appears after `MIN_IDLE` idles.
- Random frames (bytes 8'h00–8'hFF, random `s_valid`/`link_en`) with `rst` asserted mid-frame: every symbol has disparity in {−2, 0, +2} consistent with `tx_rd`. After reset, the sequence restarts at 17C.
